// File: rtl/tube_frame_capture.sv
// Receive-side capture of an 8-digit multiplexed seven-segment scan.
// Define TUBE_DP_CAPTURE_EN to also capture decimal points on frame_dp.
module tube_frame_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2,
    parameter int STALL_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tube_switch,
    input  logic [7:0]  tube_character_left,
    input  logic [7:0]  tube_character_right,
    output logic [39:0] frame_digits,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic        frame_pending,
    output logic        scan_err,
    output logic        scan_stall
`ifdef TUBE_DP_CAPTURE_EN
    ,
    output logic [7:0]  frame_dp
`endif
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(STALL_CYCLES + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] STALL_MAX   = TW'(STALL_CYCLES);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(STABLE_FRAMES);

    logic [7:0]    sw_q;
    logic [7:0]    sw_prev;
    logic [7:0]    left_q;
    logic [7:0]    right_q;
    logic          ack_q;
    logic          valid_q;
    logic [SW-1:0] settle_cnt;
    logic          latched;
    logic [TW-1:0] stall_cnt;
    logic [7:0]    seen;
    logic [39:0]   code;
    logic [39:0]   prev_snap;
    logic          prev_ok;
    logic [MW-1:0] match_cnt;

    logic          one_hot;
    logic          do_latch;
    logic          done;
    logic          same_prev;
    logic          diff_pub;
    logic          publish;
    logic [7:0]    seg;
    logic [7:0]    seen_nx;
    logic [4:0]    dec;
    logic [39:0]   code_nx;
    logic [MW-1:0] match_nx;
`ifdef TUBE_DP_CAPTURE_EN
    logic [7:0]    dp;
    logic [7:0]    prev_dp;
    logic [7:0]    dp_nx;
`endif

    function automatic logic [4:0] decode(input logic [7:0] s);
        unique case (s)
            8'hFC:   decode = 5'h00;
            8'h60:   decode = 5'h01;
            8'hDA:   decode = 5'h02;
            8'hF2:   decode = 5'h03;
            8'h66:   decode = 5'h04;
            8'hB6:   decode = 5'h05;
            8'hBE:   decode = 5'h06;
            8'hE0:   decode = 5'h07;
            8'hFE:   decode = 5'h08;
            8'hF6:   decode = 5'h09;
            8'hEE:   decode = 5'h0A;
            8'h3E:   decode = 5'h0B;
            8'h9C:   decode = 5'h0C;
            8'h7A:   decode = 5'h0D;
            8'h9E:   decode = 5'h0E;
            8'h8E:   decode = 5'h0F;
            8'h00:   decode = 5'h10;
            8'h02:   decode = 5'h11;
            default: decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        one_hot  = (sw_q != 8'd0) && ((sw_q & (sw_q - 8'd1)) == 8'd0);
        seg      = (sw_q[7:4] != 4'd0) ? left_q : right_q;
        dec      = decode({seg[7:1], 1'b0});
        do_latch = one_hot && (settle_cnt == SETTLE_LAST) && !latched;
        seen_nx  = seen;
        code_nx  = code;
`ifdef TUBE_DP_CAPTURE_EN
        dp_nx    = dp;
`endif
        if (do_latch) begin
            seen_nx = seen | sw_q;
            for (int i = 0; i < 8; i++) begin
                if (sw_q[i]) begin
                    code_nx[5*i +: 5] = dec;
`ifdef TUBE_DP_CAPTURE_EN
                    dp_nx[i] = seg[0];
`endif
                end
            end
        end
        // the digit latched on the completing cycle is part of the snapshot
        done = (seen_nx == 8'hFF);
`ifdef TUBE_DP_CAPTURE_EN
        same_prev = prev_ok && (code_nx == prev_snap) && (dp_nx == prev_dp);
        diff_pub  = (code_nx != frame_digits) || (dp_nx != frame_dp);
`else
        same_prev = prev_ok && (code_nx == prev_snap);
        diff_pub  = (code_nx != frame_digits);
`endif
        if (!same_prev)
            match_nx = MW'(1);
        else if (match_cnt == MATCH_MAX)
            match_nx = match_cnt;
        else
            match_nx = match_cnt + 1'b1;
        publish = done && (match_nx == MATCH_MAX) && diff_pub;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q          <= '0;
            sw_prev       <= '0;
            left_q        <= '0;
            right_q       <= '0;
            ack_q         <= 1'b0;
            valid_q       <= 1'b0;
            settle_cnt    <= '0;
            latched       <= 1'b0;
            stall_cnt     <= '0;
            seen          <= '0;
            code          <= '0;
            prev_snap     <= '0;
            prev_ok       <= 1'b0;
            match_cnt     <= '0;
            frame_digits  <= '0;
            frame_valid   <= 1'b0;
            frame_pending <= 1'b0;
            scan_err      <= 1'b0;
`ifdef TUBE_DP_CAPTURE_EN
            dp            <= '0;
            prev_dp       <= '0;
            frame_dp      <= '0;
`endif
        end else begin
            sw_q    <= tube_switch;
            sw_prev <= sw_q;
            left_q  <= tube_character_left;
            right_q <= tube_character_right;
            ack_q   <= frame_ack;
            valid_q <= frame_valid;
            // look at the register's D side so the first dwell cycle counts as 0
            if (tube_switch != sw_q) begin
                settle_cnt <= '0;
                latched    <= 1'b0;
            end else begin
                if (settle_cnt != SETTLE_MAX)
                    settle_cnt <= settle_cnt + 1'b1;
                if (do_latch)
                    latched <= 1'b1;
            end
            if (sw_q != sw_prev)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if ((sw_q != 8'd0) && !one_hot)
                scan_err <= 1'b1;
            code <= code_nx;
            seen <= done ? 8'd0 : seen_nx;
`ifdef TUBE_DP_CAPTURE_EN
            dp <= dp_nx;
            if (done)
                prev_dp <= dp_nx;
            if (publish)
                frame_dp <= dp_nx;
`endif
            if (done) begin
                prev_snap <= code_nx;
                prev_ok   <= 1'b1;
                match_cnt <= match_nx;
            end
            frame_valid <= publish;
            // an ack raised while frame_valid was showing is not honoured
            if (publish) begin
                frame_digits  <= code_nx;
                frame_pending <= 1'b1;
            end else if (ack_q && !valid_q) begin
                frame_pending <= 1'b0;
            end
        end
    end

    assign scan_stall = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_tube_frame_capture.sv
// Directed scans for tube_frame_capture, checked every cycle against a
// frame-level model plus hand-computed literal expectations.
module tb_tube_frame_capture;

    localparam int SETTLE = 4;
    localparam int STABLE = 2;
    localparam int STALL  = 4096;
    localparam logic [7:0] SEG_TBL [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tube_switch = 8'd0;
    logic [7:0]  seg_left = 8'd0;
    logic [7:0]  seg_right = 8'd0;
    logic        frame_ack;
    logic [39:0] frame_digits;
    logic        frame_valid;
    logic        frame_pending;
    logic        scan_err;
    logic        scan_stall;
`ifdef TUBE_DP_CAPTURE_EN
    logic [7:0]  frame_dp;
`endif

    logic        ack_manual = 1'b0;
    logic        ack_on_valid = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pub = 0;
    int          p0;
    logic [7:0]  pat [8];

    // model state
    logic [7:0]  m_cur;
    int          m_run;
    logic [39:0] m_code;
    logic [7:0]  m_dp;
    logic [7:0]  m_seen;
    logic [39:0] m_last;
    logic [7:0]  m_last_dp;
    logic        m_have_last;
    int          m_streak;
    logic [39:0] m_shown;
    logic [7:0]  m_shown_dp;
    logic        m_valid;
    logic        m_vb;
    logic        m_pending;
    logic        m_err;
    logic [7:0]  xs, xl, xr;
    logic        xa;

    always #5 clk = ~clk;

    assign frame_ack = ack_manual | (ack_on_valid & frame_valid);

    tube_frame_capture #(
        .SETTLE_CYCLES(SETTLE),
        .STABLE_FRAMES(STABLE),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tube_switch         (tube_switch),
        .tube_character_left (seg_left),
        .tube_character_right(seg_right),
        .frame_digits        (frame_digits),
        .frame_valid         (frame_valid),
        .frame_ack           (frame_ack),
        .frame_pending       (frame_pending),
        .scan_err            (scan_err),
        .scan_stall          (scan_stall)
`ifdef TUBE_DP_CAPTURE_EN
        ,
        .frame_dp            (frame_dp)
`endif
    );

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mdec(input logic [7:0] s);
        logic [7:0] m;
        m = s & 8'hFE;
        mdec = 5'h1F;
        if (m == 8'h00) mdec = 5'h10;
        if (m == 8'h02) mdec = 5'h11;
        for (int k = 0; k < 16; k++)
            if (SEG_TBL[k] == m) mdec = 5'(k);
    endfunction

    task automatic m_reset();
        m_cur = 8'd0;
        m_run = 2;
        m_code = '0;
        m_dp = '0;
        m_seen = '0;
        m_last = '0;
        m_last_dp = '0;
        m_have_last = 1'b0;
        m_streak = 0;
        m_shown = '0;
        m_shown_dp = '0;
        m_valid = 1'b0;
        m_vb = 1'b0;
        m_pending = 1'b0;
        m_err = 1'b0;
    endtask

    // one sampled input cycle; the result is what the DUT shows a cycle later
    task automatic m_step(input logic [7:0] s, input logic [7:0] l,
                          input logic [7:0] r, input logic a);
        logic ack_ok;
        logic same;
        logic diff;
        int   idx;
        logic [7:0] sg;
        if (s == m_cur) begin
            if (m_run < 100000) m_run++;
        end else begin
            m_cur = s;
            m_run = 1;
        end
        ack_ok = a && !m_vb;
        m_vb = m_valid;
        m_valid = 1'b0;
        if (s != 8'd0 && $countones(s) != 1) m_err = 1'b1;
        if ($countones(s) == 1 && m_run == SETTLE) begin
            idx = 0;
            for (int k = 0; k < 8; k++) if (s[k]) idx = k;
            sg = (idx >= 4) ? l : r;
            m_code[5*idx +: 5] = mdec(sg);
            m_dp[idx] = sg[0];
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) begin
                m_seen = '0;
                same = m_have_last && (m_code == m_last);
                diff = (m_code != m_shown);
`ifdef TUBE_DP_CAPTURE_EN
                same = same && (m_dp == m_last_dp);
                diff = diff || (m_dp != m_shown_dp);
`endif
                m_streak = same ? m_streak + 1 : 1;
                m_last = m_code;
                m_last_dp = m_dp;
                m_have_last = 1'b1;
                if (m_streak >= STABLE && diff) begin
                    m_shown = m_code;
                    m_shown_dp = m_dp;
                    m_valid = 1'b1;
                    m_pending = 1'b1;
                end
            end
        end
        if (!m_valid && ack_ok) m_pending = 1'b0;
    endtask

    task automatic check_all();
        chk("frame_digits", frame_digits, m_shown);
        chk("frame_valid", 40'(frame_valid), 40'(m_valid));
        chk("frame_pending", 40'(frame_pending), 40'(m_pending));
        chk("scan_err", 40'(scan_err), 40'(m_err));
        chk("scan_stall", 40'(scan_stall), 40'(m_run - 1 >= STALL));
`ifdef TUBE_DP_CAPTURE_EN
        chk("frame_dp", 40'(frame_dp), 40'(m_shown_dp));
`endif
        if (frame_valid) n_pub++;
    endtask

    initial begin : compare
        m_reset();
        forever begin
            @(posedge clk);
            xs = tube_switch;
            xl = seg_left;
            xr = seg_right;
            xa = frame_ack;
            if (!rst_n) begin
                m_reset();
                #1;
                check_all();
            end else begin
                #1;
                check_all();
                m_step(xs, xl, xr, xa);
            end
        end
    end

    task automatic idle(input int n);
        @(negedge clk);
        tube_switch = 8'd0;
        seg_left = 8'd0;
        seg_right = 8'd0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input int ndig, input int dwell, input int gap);
        for (int i = 0; i < ndig; i++) begin
            @(negedge clk);
            tube_switch = 8'd1 << i;
            seg_left = (i >= 4) ? pat[i] : 8'h00;
            seg_right = (i < 4) ? pat[i] : 8'h00;
            repeat (dwell - 1) @(negedge clk);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pat[i] = v;
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_digits", frame_digits, 40'd0);
        chk("rst_valid", 40'(frame_valid), 40'd0);
        chk("rst_pending", 40'(frame_pending), 40'd0);
        chk("rst_err", 40'(scan_err), 40'd0);
        chk("rst_stall", 40'(scan_stall), 40'd0);
        rst_n = 1'b1;
        idle(2);

        // "01234567" three frames, ack held on the valid cycle only
        for (int i = 0; i < 8; i++) pat[i] = SEG_TBL[i];
        p0 = n_pub;
        ack_on_valid = 1'b1;
        repeat (3) scan(8, 6, 1);
        idle(4);
        ack_on_valid = 1'b0;
        chk("t1_pubs", 40'(n_pub - p0), 40'd1);
        chk("t1_digits", frame_digits,
            {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
        chk("t1_pending", 40'(frame_pending), 40'd1);
        @(negedge clk);
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        idle(3);
        chk("t1_ack", 40'(frame_pending), 40'd0);

        // one A frame then two B frames
        p0 = n_pub;
        fill(8'hEE);
        scan(8, 6, 1);
        fill(8'h3E);
        repeat (2) scan(8, 6, 1);
        idle(4);
        chk("t2_pubs", 40'(n_pub - p0), 40'd1);
        chk("t2_digits", frame_digits, {8{5'h0B}});

        // dwell 3 latches nothing, dwell 4 latches
        p0 = n_pub;
        fill(8'h9C);
        repeat (3) scan(8, 3, 1);
        idle(4);
        chk("t3_short_pubs", 40'(n_pub - p0), 40'd0);
        chk("t3_short_digits", frame_digits, {8{5'h0B}});
        repeat (2) scan(8, 4, 1);
        idle(4);
        chk("t3_pubs", 40'(n_pub - p0), 40'd1);
        chk("t3_digits", frame_digits, {8{5'h0C}});

        // illegal select, then a legal '-' scan
        @(negedge clk);
        tube_switch = 8'b0000_0011;
        seg_right = 8'hFC;
        repeat (4) @(negedge clk);
        idle(3);
        chk("t4_err", 40'(scan_err), 40'd1);
        p0 = n_pub;
        fill(8'h02);
        repeat (2) scan(8, 5, 0);
        idle(4);
        chk("t4_pubs", 40'(n_pub - p0), 40'd1);
        chk("t4_digits", frame_digits, {8{5'h11}});
        chk("t4_err_sticky", 40'(scan_err), 40'd1);

        // undecodable pattern
        fill(8'h55);
        repeat (2) scan(8, 6, 1);
        idle(4);
        chk("t5_digits", frame_digits, {8{5'h1F}});

        // stall
        @(negedge clk);
        tube_switch = 8'h10;
        seg_left = 8'h60;
        repeat (99) @(negedge clk);
        chk("t6_not_yet", 40'(scan_stall), 40'd0);
        repeat (4100) @(negedge clk);
        chk("t6_stall", 40'(scan_stall), 40'd1);
        idle(3);
        chk("t6_unstall", 40'(scan_stall), 40'd0);

        // reset mid-frame
        fill(8'hF6);
        scan(5, 6, 1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_rst_err", 40'(scan_err), 40'd0);
        chk("t7_rst_digits", frame_digits, 40'd0);
        rst_n = 1'b1;
        idle(2);
        p0 = n_pub;
        for (int i = 0; i < 8; i++) pat[i] = SEG_TBL[7-i];
        repeat (2) scan(8, 6, 1);
        idle(4);
        chk("t7_pubs", 40'(n_pub - p0), 40'd1);
        chk("t7_digits", frame_digits,
            {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7});

        // decimal point on digit 3
        fill(8'hFC);
        pat[3] = 8'hF3;
        repeat (2) scan(8, 6, 1);
        idle(4);
        chk("t8_digits", frame_digits,
            {5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0});
`ifdef TUBE_DP_CAPTURE_EN
        chk("t8_dp", 40'(frame_dp), 40'h08);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
